// File: rtl/flappy_pkg.sv
// Shared types and constants for the flappy-bird game sequencer.
package flappy_pkg;
  localparam int GRID = 16;
  localparam logic [3:0] BIRD_START = 4'd8;

  typedef logic [GRID-1:0][GRID-1:0] frame_t;
  typedef enum logic [1:0] {IDLE = 2'd0, PLAY = 2'd1, OVER = 2'd2} game_state_t;
endpackage

// File: rtl/frame_tick_gen.sv
// Frame tick divider: one-cycle tick every FRAME_DIV clk cycles (on count FRAME_DIV-1).
module frame_tick_gen #(
  parameter int FRAME_DIV = 1562500
) (
  input  logic clk,
  input  logic reset_n,
  output logic tick
);
  localparam int CW = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(FRAME_DIV - 1);

  logic [CW-1:0] cnt;

  assign tick = (cnt == LAST);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)  cnt <= '0;
    else if (tick) cnt <= '0;
    else           cnt <= cnt + CW'(1);
  end
endmodule

// File: rtl/flappy_game_ctrl.sv
// Flappy-bird game sequencer: frame-ticked bird physics, pipe scroll pulses, collision and score.
// Optional FLAPPY_SPEEDUP_EN shortens the scroll period as the score grows.
module flappy_game_ctrl
  import flappy_pkg::*;
#(
  parameter int FRAME_DIV     = 1562500,
  parameter int SCROLL_FRAMES = 8,
  parameter int GRAV_FRAMES   = 4,
  parameter int FLAP_H        = 2,
  parameter int BIRD_COL      = 3,
  parameter int SCORE_W       = 8
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      flap,
  input  logic [GRID-1:0][GRID-1:0] GrnPixels,
  output logic                      scroll_en,
  output logic                      pipe_rst,
  output logic [GRID-1:0][GRID-1:0] RedPixels,
  output logic [3:0]                bird_row,
  output logic [SCORE_W-1:0]        score,
  output logic                      game_over,
  output logic [1:0]                state_dbg
);
  localparam int GW = (GRAV_FRAMES > 1) ? $clog2(GRAV_FRAMES) : 1;
  localparam int SW = $clog2(SCROLL_FRAMES + 1);
  localparam logic [3:0]         COL         = 4'(BIRD_COL);
  localparam logic [3:0]         FLAP_STEP   = 4'(FLAP_H);
  localparam logic [GW-1:0]      GRAV_LAST   = GW'(GRAV_FRAMES - 1);
  localparam logic [SW-1:0]      SCROLL_BASE = SW'(SCROLL_FRAMES);
  localparam logic [SCORE_W-1:0] SCORE_MAX   = '1;

  game_state_t        state_q, state_d;
  logic [3:0]         row_q, row_d;
  logic [GW-1:0]      grav_q, grav_d;
  logic [SW-1:0]      scr_q, scr_d, period_q, period_d;
  logic [SCORE_W-1:0] score_q, score_d;
  logic               pend_q, pend_d, scroll_d;
  logic               tick, fl, hit, fall_out, col_lit;
  logic               unused_grn;

  frame_tick_gen #(.FRAME_DIV(FRAME_DIV)) u_tick (
    .clk     (clk),
    .reset_n (reset_n),
    .tick    (tick)
  );

`ifdef FLAPPY_SPEEDUP_EN
  function automatic logic [SW-1:0] speedup_period(input logic [SCORE_W-1:0] s);
    int step;
    step = int'(s) >> 3;
    if (step > SCROLL_FRAMES - 2) step = SCROLL_FRAMES - 2;
    return SW'(SCROLL_FRAMES - step);
  endfunction
`endif

  // Only the bird column of the pipe frame matters to this block.
  assign unused_grn = ^GrnPixels;

  always_comb begin
    col_lit = 1'b0;
    for (int r = 0; r < GRID; r++) col_lit = col_lit | GrnPixels[r[3:0]][COL];
  end

  always_comb begin
    state_d  = state_q;
    row_d    = row_q;
    grav_d   = grav_q;
    scr_d    = scr_q;
    period_d = period_q;
    score_d  = score_q;
    scroll_d = 1'b0;
    fl       = pend_q | flap;
    pend_d   = tick ? 1'b0 : fl;
    hit      = GrnPixels[row_q][COL];
    fall_out = !fl && (grav_q == GRAV_LAST) && (row_q == 4'd15);
    if (tick) begin
      unique case (state_q)
        IDLE: if (fl) begin
          state_d  = PLAY;
          row_d    = BIRD_START;
          grav_d   = '0;
          scr_d    = '0;
          score_d  = '0;
          period_d = SCROLL_BASE;
        end
        PLAY: if (hit || fall_out) begin
          state_d = OVER;
        end else begin
          // A pending flap pre-empts gravity for this frame.
          if (fl) begin
            row_d  = (row_q < FLAP_STEP) ? 4'd0 : row_q - FLAP_STEP;
            grav_d = '0;
          end else if (grav_q == GRAV_LAST) begin
            grav_d = '0;
            row_d  = row_q + 4'd1;
          end else begin
            grav_d = grav_q + GW'(1);
          end
          if (scr_q == period_q - SW'(1)) begin
            scr_d    = '0;
            scroll_d = 1'b1;
            if (col_lit && (score_q != SCORE_MAX)) score_d = score_q + SCORE_W'(1);
`ifdef FLAPPY_SPEEDUP_EN
            period_d = speedup_period(score_d);
`else
            period_d = SCROLL_BASE;
`endif
          end else begin
            scr_d = scr_q + SW'(1);
          end
        end
        OVER: if (fl) begin
          state_d = IDLE;
          row_d   = BIRD_START;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // scroll_en is a one-cycle strobe with no acknowledge; pipe_rst is a level.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      row_q     <= BIRD_START;
      grav_q    <= '0;
      scr_q     <= '0;
      period_q  <= SCROLL_BASE;
      score_q   <= '0;
      pend_q    <= 1'b0;
      scroll_en <= 1'b0;
      pipe_rst  <= 1'b1;
    end else begin
      state_q   <= state_d;
      row_q     <= row_d;
      grav_q    <= grav_d;
      scr_q     <= scr_d;
      period_q  <= period_d;
      score_q   <= score_d;
      pend_q    <= pend_d;
      scroll_en <= scroll_d;
      pipe_rst  <= (state_d != PLAY);
    end
  end

  always_comb begin
    RedPixels             = '0;
    RedPixels[row_q][COL] = 1'b1;
  end

  assign bird_row  = row_q;
  assign score     = score_q;
  assign game_over = (state_q == OVER);
  assign state_dbg = state_q;
endmodule

// File: tb/tb_flappy_game_ctrl.sv
// Bench for flappy_game_ctrl: per-cycle expected snapshots from a frame-level game model,
// popped and compared by an independent monitor on the falling edge.
module tb_flappy_game_ctrl;
  import flappy_pkg::*;

  localparam int FD  = 4;
  localparam int SF  = 8;
  localparam int GF  = 4;
  localparam int FH  = 2;
  localparam int COL = 3;
  localparam int SMAX = 255;

  logic clk = 1'b0;
  logic reset_n;
  logic flap;
  logic [15:0][15:0] GrnPixels;
  logic scroll_en, pipe_rst, game_over;
  logic [15:0][15:0] RedPixels;
  logic [3:0] bird_row;
  logic [7:0] score;
  logic [1:0] state_dbg;

  flappy_game_ctrl #(
    .FRAME_DIV(FD), .SCROLL_FRAMES(SF), .GRAV_FRAMES(GF),
    .FLAP_H(FH), .BIRD_COL(COL), .SCORE_W(8)
  ) dut (
    .clk(clk), .reset_n(reset_n), .flap(flap), .GrnPixels(GrnPixels),
    .scroll_en(scroll_en), .pipe_rst(pipe_rst), .RedPixels(RedPixels),
    .bird_row(bird_row), .score(score), .game_over(game_over), .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [16:0] exp_q[$];
  logic [15:0][15:0] grid_v;

  // Frame-level game model
  int m_fcnt, m_row, m_grav, m_scr, m_period, m_score, m_ticks, m_scrolls;
  bit m_pend, m_scroll;
  game_state_t m_st;

  function automatic void model_reset();
    m_fcnt = 0; m_st = IDLE; m_row = 8; m_grav = 0; m_scr = 0;
    m_period = SF; m_score = 0; m_pend = 0; m_scroll = 0;
  endfunction

  function automatic void model_step(input bit f, input logic [15:0][15:0] g);
    bit tk, fl, lit;
    tk = (m_fcnt == FD - 1);
    m_fcnt = tk ? 0 : m_fcnt + 1;
    m_scroll = 0;
    fl = m_pend || f;
    m_pend = tk ? 0 : fl;
    if (!tk) return;
    m_ticks++;
    lit = 0;
    for (int r = 0; r < 16; r++) lit = lit | g[r][COL];
    case (m_st)
      IDLE: if (fl) begin
        m_st = PLAY; m_row = 8; m_grav = 0; m_scr = 0; m_score = 0; m_period = SF;
      end
      PLAY: begin
        if (g[m_row][COL]) m_st = OVER;
        else if (!fl && m_grav == GF - 1 && m_row == 15) m_st = OVER;
        else begin
          if (fl) begin
            m_row = (m_row >= FH) ? m_row - FH : 0;
            m_grav = 0;
          end else begin
            m_grav++;
            if (m_grav == GF) begin m_grav = 0; m_row++; end
          end
          m_scr++;
          if (m_scr == m_period) begin
            m_scr = 0;
            m_scroll = 1;
            m_scrolls++;
            if (lit && m_score < SMAX) m_score++;
`ifdef FLAPPY_SPEEDUP_EN
            m_period = SF - (((m_score / 8) < SF - 2) ? (m_score / 8) : SF - 2);
`else
            m_period = SF;
`endif
          end
        end
      end
      OVER: if (fl) begin m_st = IDLE; m_row = 8; end
      default: m_st = IDLE;
    endcase
  endfunction

  function automatic logic [16:0] pack_model();
    return {2'(m_st), 4'(m_row), 8'(m_score), m_scroll, (m_st != PLAY), (m_st == OVER)};
  endfunction

  task automatic check(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", name, got, exp);
    end
  endtask

  // One clock cycle of stimulus, entered and left at posedge+1.
  task automatic cycle(input bit f, input bit rn);
    flap = f; GrnPixels = grid_v; reset_n = rn;
    if (!rn) model_reset();
    exp_q.push_back(pack_model());
    @(posedge clk); #1;
    if (!rn) model_reset();
    else model_step(f, grid_v);
  endtask

  task automatic run_ticks(input int n);
    int target, guard;
    target = m_ticks + n;
    guard = 0;
    while (m_ticks < target && guard < (n + 1) * FD) begin
      cycle(0, 1);
      guard++;
    end
    check("tick_budget", (m_ticks >= target) ? 1 : 0, 1);
  endtask

  task automatic flap_once();
    while (m_fcnt == FD - 1) cycle(0, 1);
    cycle(1, 1);
  endtask

  // Monitor: compares DUT outputs against the oldest expected snapshot.
  initial begin
    logic [16:0] exp, got;
    logic [15:0][15:0] exp_red;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        exp = exp_q.pop_front();
        got = {state_dbg, bird_row, score, scroll_en, pipe_rst, game_over};
        checks++;
        if (got !== exp) begin
          errors++;
          $display("FAIL snapshot t=%0t got=%h exp=%h (state,row,score,scroll,prst,over)", $time, got, exp);
        end
        exp_red = '0;
        exp_red[exp[14:11]][COL] = 1'b1;
        checks++;
        if (RedPixels !== exp_red) begin
          errors++;
          $display("FAIL red_pixels t=%0t got=%h exp=%h", $time, RedPixels, exp_red);
        end
      end
    end
  end

  initial begin
    int target, guard;
    reset_n = 1'b0; flap = 1'b0; grid_v = '0; GrnPixels = '0;
    model_reset();
    m_ticks = 0; m_scrolls = 0;
    @(posedge clk); #1;
    cycle(0, 0);
    cycle(0, 0);
    check("rst_row", bird_row, 8);
    check("rst_score", score, 0);
    check("rst_pipe_rst", pipe_rst, 1);
    check("rst_scroll", scroll_en, 0);
    check("rst_over", game_over, 0);
    check("rst_state", state_dbg, int'(IDLE));
    repeat (5) cycle(0, 1);

    // Start game, fall 4 rows on an empty frame
    flap_once();
    run_ticks(1);
    check("start_state", state_dbg, int'(PLAY));
    check("start_pipe_rst", pipe_rst, 0);
    run_ticks(16);
    check("fall_16_ticks", bird_row, 12);

    // Asynchronous reset mid-game
    cycle(0, 1);
    flap = 1'b0; reset_n = 1'b0; #1;
    check("midrst_row", bird_row, 8);
    check("midrst_score", score, 0);
    check("midrst_pipe_rst", pipe_rst, 1);
    check("midrst_scroll", scroll_en, 0);
    check("midrst_state", state_dbg, int'(IDLE));
    cycle(0, 0);
    cycle(0, 1);

    // Flap up to the top row and saturate
    flap_once(); run_ticks(1);
    run_ticks(4);
    check("row_after_fall", bird_row, 9);
    repeat (4) begin flap_once(); run_ticks(1); end
    check("row_after_4_flaps", bird_row, 1);
    flap_once(); run_ticks(1);
    check("flap_saturate", bird_row, 0);

    // Fall off the bottom
    run_ticks(60);
    check("row_at_bottom", bird_row, 15);
    check("alive_at_bottom", game_over, 0);
    run_ticks(4);
    check("fall_out_over", game_over, 1);
    check("fall_out_row", bird_row, 15);
    run_ticks(10);

    // Pipe hit at the bird position
    flap_once(); run_ticks(1);
    check("over_to_idle", pipe_rst, 1);
    flap_once(); run_ticks(1);
    grid_v[8][COL] = 1'b1;
    run_ticks(1);
    check("hit_over", game_over, 1);
    run_ticks(12);
    grid_v = '0;
    flap_once(); run_ticks(1);
    check("hit_to_idle_state", state_dbg, int'(IDLE));
    check("hit_to_idle_prst", pipe_rst, 1);

    // Score saturation: column lit away from the bird
    grid_v[0][COL] = 1'b1;
    flap_once(); run_ticks(1);
    target = m_scrolls + 300;
    guard = 0;
    while (m_scrolls < target && guard < 20000) begin
      if (m_st == PLAY && m_row >= 10 && m_fcnt != FD - 1 && !m_pend) cycle(1, 1);
      else cycle(0, 1);
      guard++;
    end
    check("score_saturate", score, SMAX);
    check("score_alive", game_over, 0);
    run_ticks(8);
    check("score_hold", score, SMAX);

    // Randomized play
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 49) == 0) begin
        grid_v = '0;
        repeat ($urandom_range(0, 3))
          grid_v[$urandom_range(0, 15)][($urandom_range(0, 2) == 0) ? COL : $urandom_range(0, 15)] = 1'b1;
      end
      if ($urandom_range(0, 999) == 0) repeat ($urandom_range(1, 3)) cycle(0, 0);
      else cycle((m_fcnt != FD - 1) && ($urandom_range(0, 15) == 0), 1);
    end

    cycle(0, 1);
    repeat (2) @(negedge clk);
    #1;
    check("queue_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
